// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment codes are ordered {a,b,c,d,e,f,g}, active-high.
package seg_pkg;

    typedef enum logic {
        DRIVE = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGIT_W = 4;

    localparam logic [SEG_W-1:0] SEG_0   = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1   = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2   = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3   = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4   = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5   = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6   = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7   = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8   = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9   = 7'b1110011;
    localparam logic [SEG_W-1:0] SEG_A   = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_B   = 7'b0011111;
    localparam logic [SEG_W-1:0] SEG_C   = 7'b1001110;
    localparam logic [SEG_W-1:0] SEG_D   = 7'b0111101;
    localparam logic [SEG_W-1:0] SEG_E   = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_F   = 7'b1000111;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'b0000000;

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational hex digit to seven-segment decoder.
// Ports: i_digit (4-bit hex value) -> o_seg_c ({a..g}, active-high).
module seg_hex_dec
    import seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [SEG_W-1:0]   o_seg_c
);

    always_comb begin
        o_seg_c = SEG_OFF;
        case (i_digit)
            4'h0: o_seg_c = SEG_0;
            4'h1: o_seg_c = SEG_1;
            4'h2: o_seg_c = SEG_2;
            4'h3: o_seg_c = SEG_3;
            4'h4: o_seg_c = SEG_4;
            4'h5: o_seg_c = SEG_5;
            4'h6: o_seg_c = SEG_6;
            4'h7: o_seg_c = SEG_7;
            4'h8: o_seg_c = SEG_8;
            4'h9: o_seg_c = SEG_9;
            4'hA: o_seg_c = SEG_A;
            4'hB: o_seg_c = SEG_B;
            4'hC: o_seg_c = SEG_C;
            4'hD: o_seg_c = SEG_D;
            4'hE: o_seg_c = SEG_E;
            4'hF: o_seg_c = SEG_F;
            default: o_seg_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with blanking guard, hex decode,
// per-digit blink and a frame-synchronous load/ack double buffer.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   i_digits         4*NUM_DIGITS hex digits, digit 0 rightmost
//   i_dp, i_blink    per-digit decimal point / blink enable
//   i_load           strobe capturing digits/dp/blink into staging
//   o_load_ack       pulse when staged data becomes active
//   o_seg, o_seg_dp  segment pattern and decimal point, active-high
//   o_seg_enb        digit enables, active-low one-hot
//   o_frame_start    pulse on the first cycle of digit 0's slot
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 6,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYC    = 500,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] i_digits,
    input  logic [NUM_DIGITS-1:0]         i_dp,
    input  logic [NUM_DIGITS-1:0]         i_blink,
    input  logic                          i_load,
    output logic                          o_load_ack,
    output logic [SEG_W-1:0]              o_seg,
    output logic                          o_seg_dp,
    output logic [NUM_DIGITS-1:0]         o_seg_enb,
    output logic                          o_frame_start
);

    localparam int unsigned CNT_W     = (SCAN_DIV > 1) ? 32'($clog2(SCAN_DIV)) : 1;
    localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? 32'($clog2(NUM_DIGITS)) : 1;
    localparam int unsigned FC_W      = (BLINK_FRAMES > 1) ? 32'($clog2(BLINK_FRAMES)) : 1;
    localparam int unsigned DRIVE_CYC = SCAN_DIV - BLANK_CYC;
    localparam int unsigned BANK_W    = DIGIT_W * NUM_DIGITS;

    // Scan position registers hold the position shown in the NEXT cycle;
    // outputs are registered from them so they lead the pins by one cycle.
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    scan_state_t           state_q, state_d;
    logic                  run_q, run_d;
    logic [FC_W-1:0]       fc_q, fc_d;
    logic                  blink_on_q, blink_on_d;

    logic [BANK_W-1:0]     act_dig_q, act_dig_d, stg_dig_q, stg_dig_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, stg_dp_q, stg_dp_d;
    logic [NUM_DIGITS-1:0] act_blk_q, act_blk_d, stg_blk_q, stg_blk_d;
    logic                  pend_q, pend_d;

    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] enb_q, enb_d;
    logic                  ack_q, ack_d;
    logic                  fs_q, fs_d;

    logic                  at_pos0;
    logic                  boundary;
    logic [DIGIT_W-1:0]    cur_dig;
    logic                  cur_dp;
    logic                  cur_blk;
    logic                  cur_lzb;
    logic [NUM_DIGITS-1:0] lzb_mask;
    logic [SEG_W-1:0]      dec_seg_c;

    // Next cycle starts digit 0's slot; after the first post-reset cycle this
    // is the frame boundary.
    assign at_pos0  = (state_q == DRIVE) && (cnt_q == '0) && (idx_q == '0);
    assign boundary = run_q && at_pos0;

    // Slot counter, digit index and DRIVE/BLANK state.
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        state_d = state_q;
        run_d   = 1'b1;
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d   = '0;
            state_d = DRIVE;
            idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (32'(cnt_d) >= DRIVE_CYC) ? BLANK : DRIVE;
        end
    end

    // Frame counter and blink phase advance on each frame boundary.
    always_comb begin
        fc_d       = fc_q;
        blink_on_d = blink_on_q;
        if (boundary) begin
            if (fc_q == FC_W'(BLINK_FRAMES - 1)) begin
                fc_d       = '0;
                blink_on_d = ~blink_on_q;
            end else begin
                fc_d = fc_q + FC_W'(1);
            end
        end
    end

    // Load handshake: staging captures on i_load, active swaps on boundary.
    always_comb begin
        stg_dig_d = stg_dig_q;
        stg_dp_d  = stg_dp_q;
        stg_blk_d = stg_blk_q;
        act_dig_d = act_dig_q;
        act_dp_d  = act_dp_q;
        act_blk_d = act_blk_q;
        pend_d    = pend_q;
        ack_d     = 1'b0;
        if (i_load) begin
            stg_dig_d = i_digits;
            stg_dp_d  = i_dp;
            stg_blk_d = i_blink;
        end
        if (boundary) begin
            if (i_load) begin
                act_dig_d = i_digits;
                act_dp_d  = i_dp;
                act_blk_d = i_blink;
                ack_d     = 1'b1;
            end else if (pend_q) begin
                act_dig_d = stg_dig_q;
                act_dp_d  = stg_dp_q;
                act_blk_d = stg_blk_q;
                ack_d     = 1'b1;
            end
            pend_d = 1'b0;
        end else if (i_load) begin
            pend_d = 1'b1;
        end
    end

    // Leading-zero blanking mask over the bank that will be displayed.
`ifdef SEG_SCAN_LZB_EN
    always_comb begin
        logic lead;
        lzb_mask = '0;
        lead     = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (lead && (act_dig_d[k*DIGIT_W +: DIGIT_W] == '0) && !act_dp_d[k]) begin
                lzb_mask[k] = 1'b1;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    assign lzb_mask = '0;
`endif

    // Select the digit being scanned from the bank taking effect this edge.
    always_comb begin
        cur_dig = '0;
        cur_dp  = 1'b0;
        cur_blk = 1'b0;
        cur_lzb = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_dig = act_dig_d[k*DIGIT_W +: DIGIT_W];
                cur_dp  = act_dp_d[k];
                cur_blk = act_blk_d[k];
                cur_lzb = lzb_mask[k];
            end
        end
    end

    seg_hex_dec u_dec (
        .i_digit (cur_dig),
        .o_seg_c (dec_seg_c)
    );

    // Output pattern for the position held in the scan registers.
    always_comb begin
        seg_d = SEG_OFF;
        dp_d  = 1'b0;
        enb_d = '1;
        fs_d  = at_pos0;
        if (state_q == DRIVE) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    enb_d[k] = 1'b0;
                end
            end
            seg_d = cur_lzb ? SEG_OFF : dec_seg_c;
            dp_d  = cur_dp;
            if (!blink_on_d && cur_blk) begin
                seg_d = SEG_OFF;
                dp_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            state_q    <= DRIVE;
            run_q      <= 1'b0;
            fc_q       <= '0;
            blink_on_q <= 1'b1;
            act_dig_q  <= '0;
            act_dp_q   <= '0;
            act_blk_q  <= '0;
            stg_dig_q  <= '0;
            stg_dp_q   <= '0;
            stg_blk_q  <= '0;
            pend_q     <= 1'b0;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b0;
            enb_q      <= '1;
            ack_q      <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
            run_q      <= run_d;
            fc_q       <= fc_d;
            blink_on_q <= blink_on_d;
            act_dig_q  <= act_dig_d;
            act_dp_q   <= act_dp_d;
            act_blk_q  <= act_blk_d;
            stg_dig_q  <= stg_dig_d;
            stg_dp_q   <= stg_dp_d;
            stg_blk_q  <= stg_blk_d;
            pend_q     <= pend_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            enb_q      <= enb_d;
            ack_q      <= ack_d;
            fs_q       <= fs_d;
        end
    end

    assign o_seg         = seg_q;
    assign o_seg_dp      = dp_q;
    assign o_seg_enb     = enb_q;
    assign o_load_ack    = ack_q;
    assign o_frame_start = fs_q;

endmodule
